// File: rtl/gnrc_arb_pkg.sv
// Shared types and helpers for the generic arbiter family.
// Index-width and reset-pointer helpers keep the derived widths consistent across modules.
package gnrc_arb_pkg;

  typedef enum logic {
    LockNone = 1'b0,
    LockIn   = 1'b1
  } lock_mode_e;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pointer value after reset, chosen so requester 0 wins first.
  function automatic int unsigned rst_ptr(input int unsigned n);
    return n - 1;
  endfunction

endpackage

// File: rtl/gnrc_bin2onehot.sv
// Binary-to-one-hot decoder with enable; OUT_W may be smaller than 2**IN_W.
module gnrc_bin2onehot #(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = 4
) (
  input  logic [IN_W-1:0]  in_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] out_o
);

  always_comb begin
    out_o = '0;
    for (int k = 0; k < int'(OUT_W); k++) begin
      out_o[k] = en_i && (in_i == IN_W'(k));
    end
  end

endmodule

// File: rtl/gnrc_lzc_bin.sv
// Generic zero counter: MODE 0 returns the index of the lowest set bit (trailing zeros),
// MODE 1 returns the leading-zero count. empty_o flags an all-zero input (count is then 0).
module gnrc_lzc_bin
  import gnrc_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = clog2_min1(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  always_comb begin
    cnt_o   = '0;
    empty_o = ~|in_i;
    if (MODE == 0) begin
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (in_i[i]) cnt_o = CNT_W'(int'(WIDTH) - 1 - i);
      end
    end
  end

endmodule

// File: rtl/gnrc_rr_arbiter.sv
// Round-robin arbiter with valid/ready handshake and optional grant lock while stalled.
// Grant is combinational from req_i and state; both index and one-hot forms are provided.
module gnrc_rr_arbiter
  import gnrc_arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned LOCK_IN = 1,
  parameter int unsigned IDX_W   = clog2_min1(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam lock_mode_e       LockMode = (LOCK_IN != 0) ? LockIn : LockNone;
  localparam bit               LockEn   = (LockMode == LockIn);
  localparam logic [IDX_W-1:0] PtrRst   = IDX_W'(rst_ptr(N));

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic [N-1:0]     mask, hi_req;
  logic [IDX_W-1:0] hi_idx, full_idx;
  logic             hi_empty, full_empty;
  logic             lock_req, lock_hit;
  logic             xfer, stall;

  always_comb begin
    mask     = '0;
    lock_req = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      mask[k] = (IDX_W'(k) > ptr_q);
      if (lock_idx_q == IDX_W'(k)) lock_req = req_i[k];
    end
  end

  assign hi_req = req_i & mask;

  gnrc_lzc_bin #(
    .WIDTH (N),
    .MODE  (0),
    .CNT_W (IDX_W)
  ) u_lzc_hi (
    .in_i    (hi_req),
    .cnt_o   (hi_idx),
    .empty_o (hi_empty)
  );

  gnrc_lzc_bin #(
    .WIDTH (N),
    .MODE  (0),
    .CNT_W (IDX_W)
  ) u_lzc_full (
    .in_i    (req_i),
    .cnt_o   (full_idx),
    .empty_o (full_empty)
  );

  // A lock whose requester has dropped is ignored and normal arbitration takes over.
  assign lock_hit = LockEn && lock_q && lock_req;
  assign valid_o  = ~full_empty;

  always_comb begin
    idx_o = '0;
    if (valid_o) begin
      if (lock_hit)       idx_o = lock_idx_q;
      else if (!hi_empty) idx_o = hi_idx;
      else                idx_o = full_idx;
    end
  end

  gnrc_bin2onehot #(
    .IN_W  (IDX_W),
    .OUT_W (N)
  ) u_onehot (
    .in_i  (idx_o),
    .en_i  (valid_o),
    .out_o (gnt_o)
  );

  assign xfer  = valid_o && ready_i;
  assign stall = valid_o && !ready_i;

  always_comb begin
    ptr_d      = xfer ? idx_o : ptr_q;
    lock_d     = 1'b0;
    lock_idx_d = lock_idx_q;
    if (LockEn) begin
      // Any stalled grant (fresh, held or re-arbitrated after a drop) is pinned.
      lock_d = stall;
      if (stall) lock_idx_d = idx_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= PtrRst;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: tb/tb_gnrc_rr_arbiter.sv
// Scoreboard bench for gnrc_rr_arbiter: N=4 with lock, N=13 without lock, N=1.
module tb_gnrc_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4 = 1'b1, rst13 = 1'b1, rst1 = 1'b1;
  logic [3:0]  req4 = '0;
  logic [12:0] req13 = '0;
  logic [0:0]  req1 = '0;
  logic        rdy4 = 1'b0, rdy13 = 1'b0, rdy1 = 1'b0;
  logic [3:0]  gnt4;
  logic [12:0] gnt13;
  logic [0:0]  gnt1;
  logic [1:0]  idx4;
  logic [3:0]  idx13;
  logic [0:0]  idx1;
  logic        val4, val13, val1;

  gnrc_rr_arbiter #(.N(4), .LOCK_IN(1)) u_dut4 (
    .clk_i (clk), .rst_i (rst4), .req_i (req4), .gnt_o (gnt4),
    .idx_o (idx4), .valid_o (val4), .ready_i (rdy4)
  );

  gnrc_rr_arbiter #(.N(13), .LOCK_IN(0)) u_dut13 (
    .clk_i (clk), .rst_i (rst13), .req_i (req13), .gnt_o (gnt13),
    .idx_o (idx13), .valid_o (val13), .ready_i (rdy13)
  );

  gnrc_rr_arbiter #(.N(1), .LOCK_IN(1)) u_dut1 (
    .clk_i (clk), .rst_i (rst1), .req_i (req1), .gnt_o (gnt1),
    .idx_o (idx1), .valid_o (val1), .ready_i (rdy1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          dut;
    string       tag;
    logic [63:0] idx;
    logic [63:0] gnt;
    logic        valid;
  } exp_t;

  exp_t sbq[$];

  task automatic sb_compare();
    exp_t e;
    if (sbq.size() == 0) begin
      check_val("sb_underflow", 64'd0, 64'd1);
      return;
    end
    e = sbq.pop_front();
    case (e.dut)
      0: begin
        check_val({e.tag, "_idx"}, 64'(idx4), e.idx);
        check_val({e.tag, "_gnt"}, 64'(gnt4), e.gnt);
        check_val({e.tag, "_valid"}, 64'(val4), 64'(e.valid));
      end
      1: begin
        check_val({e.tag, "_idx"}, 64'(idx13), e.idx);
        check_val({e.tag, "_gnt"}, 64'(gnt13), e.gnt);
        check_val({e.tag, "_valid"}, 64'(val13), 64'(e.valid));
      end
      default: begin
        check_val({e.tag, "_idx"}, 64'(idx1), e.idx);
        check_val({e.tag, "_gnt"}, 64'(gnt1), e.gnt);
        check_val({e.tag, "_valid"}, 64'(val1), 64'(e.valid));
      end
    endcase
  endtask

  // Inputs change 1 after a rising edge, outputs are sampled 2 later, well clear of edges.
  task automatic step4(input string tag, input logic [3:0] req, input logic rdy,
                       input int eidx, input logic [3:0] egnt);
    req4 = req;
    rdy4 = rdy;
    sbq.push_back('{dut: 0, tag: tag, idx: 64'(eidx), gnt: 64'(egnt), valid: |egnt});
    #2;
    sb_compare();
    @(posedge clk);
    #1;
  endtask

  task automatic step13(input string tag, input logic [12:0] req, input logic rdy,
                        input int eidx, input logic [12:0] egnt);
    req13 = req;
    rdy13 = rdy;
    sbq.push_back('{dut: 1, tag: tag, idx: 64'(eidx), gnt: 64'(egnt), valid: |egnt});
    #2;
    sb_compare();
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input string tag, input logic req, input logic rdy);
    req1 = req;
    rdy1 = rdy;
    sbq.push_back('{dut: 2, tag: tag, idx: 64'd0, gnt: 64'(req), valid: req});
    #2;
    sb_compare();
    @(posedge clk);
    #1;
  endtask

  // Reference rotation: first pending requester strictly after ptr, wrapping.
  function automatic int model_rr(input logic [12:0] pend, input int ptr);
    for (int off = 1; off <= 13; off++) begin
      if (pend[(ptr + off) % 13]) return (ptr + off) % 13;
    end
    return -1;
  endfunction

  initial begin
    logic [12:0] pend;
    logic [15:0] gnt_ext;
    logic        rdy;
    int          ptr_m, eidx;
    int          wait_cnt [13];

    @(posedge clk);
    #1;
    step4("rst4", 4'b0000, 1'b0, 0, 4'b0000);
    rst4 = 1'b0; rst13 = 1'b0; rst1 = 1'b0;

    // Full rotation from requester 0.
    step4("rot0", 4'b1111, 1'b1, 0, 4'b0001);
    step4("rot1", 4'b1111, 1'b1, 1, 4'b0010);
    step4("rot2", 4'b1111, 1'b1, 2, 4'b0100);
    step4("rot3", 4'b1111, 1'b1, 3, 4'b1000);
    step4("rot4", 4'b1111, 1'b1, 0, 4'b0001);
    step4("rot5", 4'b1111, 1'b1, 1, 4'b0010);

    rst4 = 1'b1; #1; rst4 = 1'b0;
    step4("alt0", 4'b1010, 1'b1, 1, 4'b0010);
    step4("alt1", 4'b1010, 1'b1, 3, 4'b1000);
    step4("alt2", 4'b1010, 1'b1, 1, 4'b0010);
    step4("alt3", 4'b1010, 1'b1, 3, 4'b1000);

    // Stall on 1; requester 0 would win unlocked (ptr=3) but the lock holds 1.
    step4("lock0", 4'b0110, 1'b0, 1, 4'b0010);
    step4("lock1", 4'b0111, 1'b0, 1, 4'b0010);
    step4("lock2", 4'b0111, 1'b0, 1, 4'b0010);
    step4("lock_xfer", 4'b0111, 1'b1, 1, 4'b0010);
    step4("lock_next", 4'b0110, 1'b0, 2, 4'b0100);

    // Locked requester 2 drops: re-arbitrate to 1, which then stays pinned.
    step4("drop", 4'b0010, 1'b0, 1, 4'b0010);
    step4("relock", 4'b0110, 1'b0, 1, 4'b0010);
    step4("relock_xfer", 4'b0110, 1'b1, 1, 4'b0010);

    // Lock on 3, then asynchronous reset between edges discards it.
    step4("lock3", 4'b1000, 1'b0, 3, 4'b1000);
    step4("lock3_hold", 4'b1001, 1'b0, 3, 4'b1000);
    req4 = 4'b1001;
    rst4 = 1'b1; #1; rst4 = 1'b0;
    step4("post_rst0", 4'b1111, 1'b1, 0, 4'b0001);
    step4("post_rst1", 4'b1111, 1'b1, 1, 4'b0010);

    // N=13 without lock: the grant may move during a stall.
    step13("n13_top", 13'h1000, 1'b0, 12, 13'h1000);
    step13("n13_wrap", 13'h1FFF, 1'b1, 0, 13'h0001);
    step13("n13_next", 13'h1FFF, 1'b1, 1, 13'h0002);

    step1("n1_idle", 1'b0, 1'b1);
    step1("n1_req", 1'b1, 1'b0);
    step1("n1_xfer", 1'b1, 1'b1);

    rst13 = 1'b1; #1; rst13 = 1'b0;
    pend  = '0;
    ptr_m = 12;
    for (int k = 0; k < 13; k++) wait_cnt[k] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      pend  = pend | (13'($urandom()) & 13'($urandom()));
      rdy   = 1'($urandom_range(0, 1));
      eidx  = model_rr(pend, ptr_m);
      req13 = pend;
      rdy13 = rdy;
      sbq.push_back('{dut: 1, tag: "rnd", idx: (eidx < 0) ? 64'd0 : 64'(eidx),
                      gnt: (eidx < 0) ? 64'd0 : (64'd1 << eidx), valid: (eidx >= 0)});
      #2;
      sb_compare();
      gnt_ext = 16'(gnt13);
      check_val("inv_onehot", 64'($onehot0(gnt13)), 64'd1);
      check_val("inv_idx", 64'(gnt_ext[idx13]), 64'(val13));
      check_val("inv_subset", 64'(gnt13 & ~req13), 64'd0);
      if (eidx >= 0 && rdy) begin
        check_val("fairness", 64'(wait_cnt[eidx] + 1 <= 13), 64'd1);
        wait_cnt[eidx] = 0;
        for (int k = 0; k < 13; k++) if (k != eidx && pend[k]) wait_cnt[k]++;
        pend[eidx] = 1'b0;
        ptr_m      = eidx;
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
